// File: rtl/mem_boot_loader_pkg.sv
// mem_boot_loader_pkg: state encodings and default constants shared by the boot loader files
package mem_boot_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CHK, S_RUN} state_t;
  localparam int ADDR_W_DEF = 9;
  localparam logic [7:0] SYNC_LOAD_DEF = 8'hA5;
  localparam logic [7:0] SYNC_RUN_DEF = 8'h5A;
endpackage

// File: rtl/mem_boot_loader_wr.sv
// mem_boot_loader_wr: registered memory write stage with a wrapping byte pointer
module mem_boot_loader_wr
  import mem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_h,
  input  logic              ld_l,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dataout,
  output logic              m_we
);
  logic [ADDR_W-1:0] ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr       <= '0;
      m_addr    <= '0;
      m_dataout <= '0;
      m_we      <= 1'b0;
    end else begin
      m_we <= wr;
      // only the low bits of the high address byte reach the pointer
      if (ld_h) ptr <= ADDR_W'({din, ptr[7:0]});
      if (ld_l) ptr[7:0] <= din;
      if (wr) begin
        m_addr    <= ptr;
        m_dataout <= din;
        ptr       <= ptr + 1'b1;
      end
    end
endmodule

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: framed byte-stream loader into the shared I/D memory, with CPU run command
// Optional inter-byte timeout compiled in with MEM_BOOT_LOADER_TIMEOUT_EN.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 8,
  parameter logic [7:0] SYNC_LOAD = SYNC_LOAD_DEF,
  parameter logic [7:0] SYNC_RUN = SYNC_RUN_DEF
`ifdef MEM_BOOT_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              m_sel,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dataout,
  output logic              m_we,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy,
  output logic              err_chk,
  output logic [7:0]        frame_cnt
);
  state_t            state;
  logic              acc;
  logic [DATA_W:0]   cnt;
  logic [DATA_W-1:0] sum;
  assign acc = s_valid && s_ready;
  mem_boot_loader_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
    .clk       (clk),
    .rst       (rst),
    .ld_h      (acc && state == S_ADDR_H),
    .ld_l      (acc && state == S_ADDR_L),
    .wr        (acc && state == S_DATA),
    .din       (s_data),
    .m_addr    (m_addr),
    .m_dataout (m_dataout),
    .m_we      (m_we)
  );
`ifdef MEM_BOOT_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout;
  assign timeout = busy && !s_valid && to_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) to_cnt <= '0;
    else to_cnt <= (acc || !busy) ? '0 : !s_valid ? to_cnt + 1'b1 : to_cnt;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= S_IDLE;
      s_ready    <= 1'b1;
      m_sel      <= 1'b0;
      cpu_enable <= 1'b0;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
      err_chk    <= 1'b0;
      frame_cnt  <= '0;
      cnt        <= '0;
      sum        <= '0;
    end else begin
      cpu_start <= 1'b0;
`ifdef MEM_BOOT_LOADER_TIMEOUT_EN
      if (timeout) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        m_sel   <= 1'b0;
        err_chk <= 1'b1;
      end else
`endif
      unique case (state)
        S_IDLE: if (acc) begin
          if (s_data == SYNC_LOAD) begin
            state      <= S_ADDR_H;
            busy       <= 1'b1;
            cpu_enable <= 1'b0;
            m_sel      <= 1'b1;
            err_chk    <= 1'b0;
          end else if (s_data == SYNC_RUN) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            s_ready    <= 1'b0;
            cpu_enable <= 1'b1;
            cpu_start  <= 1'b1;
            m_sel      <= 1'b0;
          end
        end
        S_ADDR_H: if (acc) state <= S_ADDR_L;
        S_ADDR_L: if (acc) state <= S_LEN;
        S_LEN: if (acc) begin
          cnt   <= {s_data == '0, s_data};
          sum   <= '0;
          state <= S_DATA;
        end
        S_DATA: if (acc) begin
          cnt <= cnt - 1'b1;
          sum <= sum + s_data;
          if (cnt == (DATA_W + 1)'(1)) state <= S_CHK;
        end
        // the last write pulse retires on the same edge the checksum byte lands
        S_CHK: if (acc) begin
          if (s_data == sum) frame_cnt <= frame_cnt + 1'b1;
          else err_chk <= 1'b1;
          state <= S_IDLE;
          busy  <= 1'b0;
          m_sel <= 1'b0;
        end
        S_RUN: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: scoreboard bench for the boot loader (timeout case with MEM_BOOT_LOADER_TIMEOUT_EN)
module tb_mem_boot_loader;
  logic        clk = 0, rst = 1, s_valid = 0;
  logic [7:0]  s_data = 0;
  logic        s_ready, m_sel, m_we, cpu_enable, cpu_start, busy, err_chk;
  logic [7:0]  m_dataout, frame_cnt;
  logic [8:0]  m_addr;
  logic [7:0]  mem [512];
  logic [7:0]  pay [$];
  logic [16:0] exp_q [$];
  logic [16:0] e;
  int checks = 0, errors = 0, we_run = 0, last_run = 0, start_cnt = 0;

  always #5 clk = ~clk;

  mem_boot_loader #(
    .ADDR_W(9)
`ifdef MEM_BOOT_LOADER_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_sel(m_sel), .m_addr(m_addr), .m_dataout(m_dataout), .m_we(m_we),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start), .busy(busy),
    .err_chk(err_chk), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_start) start_cnt++;
    if (m_we) begin
      we_run++;
      mem[m_addr] = m_dataout;
      check("we_sel", 32'(m_sel), 1);
      check("sb_depth", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(m_addr), 32'(e[16:8]));
        check("wr_data", 32'(m_dataout), 32'(e[7:0]));
      end
    end else begin
      if (we_run != 0) last_run = we_run;
      we_run = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    s_data = b;
    s_valid = 1;
    while (!s_ready && n < 8) begin @(posedge clk); #1; n++; end
    check("ready", 32'(s_ready), 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] sum8();
    logic [7:0] s = 0;
    foreach (pay[i]) s += pay[i];
    return s;
  endfunction

  task automatic load(input logic [8:0] a, input logic [7:0] chk);
    send(8'hA5);
    check("sync_err_clr", 32'(err_chk), 0);
    check("sync_sel", 32'(m_sel), 1);
    check("sync_busy", 32'(busy), 1);
    check("sync_cpu_en", 32'(cpu_enable), 0);
    send({7'd0, a[8]});
    send(a[7:0]);
    send(8'(pay.size()));
    foreach (pay[i]) begin
      exp_q.push_back({9'(a + 9'(i)), pay[i]});
      send(pay[i]);
    end
    send(chk);
    s_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_ready", 32'(s_ready), 1);
    check("rst_sel", 32'(m_sel), 0);
    check("rst_addr", 32'(m_addr), 0);
    check("rst_dout", 32'(m_dataout), 0);
    check("rst_we", 32'(m_we), 0);
    check("rst_cpu_en", 32'(cpu_enable), 0);
    check("rst_start", 32'(cpu_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_chk), 0);
    check("rst_frames", 32'(frame_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 0;
    @(posedge clk); #1;

    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(9'h020, 8'hAA);
    for (int i = 0; i < 4; i++) check("load_mem", 32'(mem[32 + i]), 32'(pay[i]));
    check("load_burst", last_run, 4);
    check("load_frames", 32'(frame_cnt), 1);
    check("load_err", 32'(err_chk), 0);
    check("load_sel", 32'(m_sel), 0);
    check("load_busy", 32'(busy), 0);

    pay = '{8'h7F};
    load(9'h020, 8'h00);
    check("bad_mem", 32'(mem[32]), 32'h7F);
    check("bad_err", 32'(err_chk), 1);
    check("bad_frames", 32'(frame_cnt), 1);
    check("bad_sel", 32'(m_sel), 0);

    pay = '{8'h01, 8'h02};
    load(9'h1FF, 8'h03);
    check("wrap_mem511", 32'(mem[511]), 32'h01);
    check("wrap_mem0", 32'(mem[0]), 32'h02);
    check("wrap_addr", 32'(m_addr), 0);
    check("wrap_err", 32'(err_chk), 0);
    check("wrap_frames", 32'(frame_cnt), 2);

    send(8'h5A);
    s_valid = 0;
    check("run_start", 32'(cpu_start), 1);
    check("run_cpu_en", 32'(cpu_enable), 1);
    check("run_sel", 32'(m_sel), 0);
    check("run_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    check("run_start_end", 32'(cpu_start), 0);
    check("run_ready_back", 32'(s_ready), 1);
    check("run_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("run_start_cnt", start_cnt, 1);
    check("run_cpu_hold", 32'(cpu_enable), 1);

    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i * 7 + 3));
    load(9'h100, sum8());
    check("len256_burst", last_run, 256);
    check("len256_frames", 32'(frame_cnt), 3);
    check("len256_err", 32'(err_chk), 0);

    send(8'hA5); send(8'h00); send(8'h20); send(8'h04);
    exp_q.push_back({9'h020, 8'h55});
    exp_q.push_back({9'h021, 8'h66});
    send(8'h55); send(8'h66);
    s_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    check_reset();
    @(posedge clk); #1;
    rst = 0;
    check("rst_mem32", 32'(mem[32]), 32'h55);
    check("rst_mem33", 32'(mem[33]), 32'h66);
    send(8'h11); send(8'h22);
    s_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_busy", 32'(busy), 0);
    check("stray_sel", 32'(m_sel), 0);
    pay = '{8'h99};
    load(9'h040, 8'h99);
    check("after_rst_mem", 32'(mem[64]), 32'h99);
    check("after_rst_frames", 32'(frame_cnt), 1);

`ifdef MEM_BOOT_LOADER_TIMEOUT_EN
    send(8'hA5); send(8'h00); send(8'h20);
    s_valid = 0;
    repeat (16) @(posedge clk);
    #1;
    check("to_err", 32'(err_chk), 1);
    check("to_busy", 32'(busy), 0);
    check("to_sel", 32'(m_sel), 0);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
- Byte-stream boot loader upstream of the shared 8-bit I/D memory (I_MEMORY_8BIT) and SERIAL_CPU_8BIT.
- Receives framed bytes over a valid/ready stream, writes the payload into memory through the memory's write port, and checks a frame checksum.
- On a run command it releases memory to the CPU and pulses start.
- Replaces hierarchical memory preloading in system benches and silicon bring-up.

Parameters:
- ADDR_W, 9, memory byte-address width; must match the memory's addr port.
- DATA_W, 8, byte width; fixed at 8, others unsupported.
- SYNC_LOAD, 8'hA5, header byte that opens a load frame.
- SYNC_RUN, 8'h5A, header byte that starts the CPU.
- TIMEOUT_CYC, 1024, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts a byte; a beat transfers when s_valid && s_ready.
- m_sel  out  1  1 = loader owns the memory address/data/we mux, 0 = CPU owns it.
- m_addr  out  ADDR_W  memory write address.
- m_dataout  out  8  memory write data.
- m_we  out  1  memory write enable, one cycle per byte.
- cpu_enable  out  1  drives the CPU enable input.
- cpu_start  out  1  one-cycle start pulse to the CPU.
- busy  out  1  frame in progress (state not IDLE).
- err_chk  out  1  sticky checksum error; cleared on the next accepted SYNC_LOAD.
- frame_cnt  out  8  good load frames completed; wraps 255->0.

Behaviour:
- Reset values: s_ready=1, m_sel=0, m_addr=0, m_dataout=0, m_we=0, cpu_enable=0, cpu_start=0, busy=0, err_chk=0, frame_cnt=0, state=IDLE.
- Reset mid-frame aborts immediately; memory contents already written stay as they are.
- Frame format (load): SYNC_LOAD, ADDR_H (bit0 = addr[8], other bits ignored), ADDR_L, LEN (0 encodes 256), LEN data bytes, CHK.
- CHK equals the 8-bit modulo-256 sum of the data bytes.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN, DATA, CHK, RUN.
- IDLE:
  - Accepted SYNC_LOAD -> ADDR_H. On the same edge: cpu_enable<=0, m_sel<=1, err_chk<=0.
  - Accepted SYNC_RUN -> RUN.
  - Any other byte is consumed and discarded; stay in IDLE.
- ADDR_H, ADDR_L, LEN: each accepted byte advances one state. LEN loads the remaining-byte counter (9 bits) and clears the running sum.
- DATA, write timing: each accepted byte is registered into m_dataout with m_addr = current pointer, and m_we=1 on the following cycle (write latency 1 cycle).
- DATA, pointer and exit: the pointer increments after each byte, wrapping 511->0. The running sum accumulates each byte. Counter reaching 0 -> CHK.
- CHK:
  - Match -> frame_cnt+1.
  - Mismatch -> err_chk<=1.
  - Either way -> IDLE. m_sel stays 1 until the last m_we has retired, then drops to 0.
- RUN:
  - One cycle: cpu_enable<=1 (held), cpu_start=1 for exactly one cycle, m_sel=0 -> IDLE.
  - cpu_enable stays high until the next SYNC_LOAD or reset.
- s_ready is 1 in all states except RUN, and except the cycle after CHK while a write is still pending.
- Back-to-back bytes (s_valid held high) are accepted at 1 byte/clk, with no bubbles inside DATA.
- s_valid low inside a frame stalls the FSM indefinitely (unless the optional feature is compiled in).
- A SYNC value appearing inside a frame is treated as ordinary data; there is no resync.

Optional Feature:
- Macro: MEM_BOOT_LOADER_TIMEOUT_EN.
- With it: a counter resets on every accepted byte and counts while busy and s_valid=0. Reaching TIMEOUT_CYC sets err_chk=1, returns to IDLE, and drops m_sel after any pending write; bytes already written are kept.
- Without it: no counter, and the stall is unbounded.

Decomposition:
- Shared package (DEFINE_CPU.v-style include): the state encodings (3-bit), SYNC_LOAD and SYNC_RUN values, and the ADDR_W default.
- One natural sub-module: mem_boot_loader_wr, a registered write stage holding m_addr, m_dataout, m_we and the pointer increment/wrap.
- FSM, checksum and frame counter stay in the top module.

Test Plan:
- Load: A5,00,20,04,11,22,33,44,AA -> memory[32..35]=11,22,33,44; four m_we pulses on consecutive cycles; frame_cnt=1; err_chk=0.
- Bad checksum: A5,00,20,01,7F,00 -> memory[32]=7F; err_chk=1; frame_cnt unchanged; next A5 clears err_chk.
- Wrap: A5,01,FF,02,01,02,03 -> memory[511]=01, memory[0]=02; m_addr wraps; err_chk=0.
- Run: after a load, send 5A -> cpu_start high exactly one cycle; cpu_enable stays 1; m_sel=0. A following A5 drops cpu_enable the same cycle it is accepted.
- Reset mid-DATA: assert rst after 2 of 4 data bytes -> all outputs return to reset values at once; memory[32..33] keep their written bytes; stray bytes after reset are discarded in IDLE.
- Timeout (macro defined, TIMEOUT_CYC=16): A5,00,20 then s_valid=0 for 16 cycles -> err_chk=1, busy=0, m_sel=0.
